// File: rtl/supernova_dcache_arbiter.sv
// Round-robin arbiter granting one requester at a time a single D-Cache access.
// Optional ack-wait timeout compiled in with `define SUPERNOVA_DCACHE_ARB_TIMEOUT_EN.

package stu_pkg;
  parameter int unsigned XLEN           = 64;
  parameter int unsigned PHYS_ADDR_SIZE = 56;
endpackage

module supernova_dcache_arbiter #(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           flush_in,
  input  logic [N_REQ-1:0]                               req_valid_in,
  input  logic [N_REQ-1:0]                               req_we_in,
  input  logic [N_REQ-1:0][stu_pkg::PHYS_ADDR_SIZE-1:0]  req_addr_in,
  input  logic [N_REQ-1:0][stu_pkg::XLEN-1:0]            req_wdata_in,
  input  logic [N_REQ-1:0][7:0]                          req_wstrb_in,
  output logic [N_REQ-1:0]                               req_ack_out,
  output logic [N_REQ-1:0]                               req_err_out,
  output logic [stu_pkg::XLEN-1:0]                       req_rdata_out,
  output logic                                           dcache_req_out,
  output logic                                           dcache_we_out,
  output logic [stu_pkg::PHYS_ADDR_SIZE-1:0]             dcache_addr_pa_out,
  output logic [stu_pkg::XLEN-1:0]                       dcache_wdata_out,
  output logic [7:0]                                     dcache_wstrb_out,
  input  logic [stu_pkg::XLEN-1:0]                       dcache_rdata_in,
  input  logic                                           dcache_ack_in,
  output logic                                           busy_out,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]   grant_idx_out
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  rr_q;
  logic [IDX_W-1:0]                  owner_q;
  logic [IDX_W-1:0]                  owner_next;
  logic [IDX_W-1:0]                  win_idx;
  logic [IDX_W-1:0]                  cand_idx;
  logic                              win_found;
  logic                              we_q;
  logic [stu_pkg::PHYS_ADDR_SIZE-1:0] addr_q;
  logic [stu_pkg::XLEN-1:0]          wdata_q;
  logic [7:0]                        wstrb_q;
  logic                              squash_q;
  logic                              squash_eff;
  logic                              grant;
  logic                              timeout_hit;
  logic                              complete;

  // Round-robin search starting at rr_q; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_idx = IDX_W'((32'(rr_q) + i) % N_REQ);
      if (!win_found && req_valid_in[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign grant      = (state_q == IDLE) && win_found && !flush_in;
  assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  // A flush arriving in the same cycle as the ack still squashes a load.
  assign squash_eff = squash_q || ((state_q == BUSY) && flush_in && !we_q);

`ifdef SUPERNOVA_DCACHE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if (!dcache_ack_in) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Counter reads 0 on the first BUSY cycle, so the limit hits on cycle TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == BUSY) && !dcache_ack_in &&
                       ((32'(tmo_cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = (state_q == BUSY) && (dcache_ack_in || timeout_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant)    state_d = BUSY;
      BUSY:    if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ack_out   = '0;
    req_err_out   = '0;
    req_rdata_out = '0;
    if ((state_q == BUSY) && dcache_ack_in && !squash_eff) begin
      req_ack_out[owner_q] = 1'b1;
      req_rdata_out        = dcache_rdata_in;
    end
    if (timeout_hit && !squash_eff) begin
      req_err_out[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q     <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        squash_q <= 1'b0;
        if (grant) begin
          owner_q <= win_idx;
          we_q    <= req_we_in[win_idx];
          addr_q  <= req_addr_in[win_idx];
          wdata_q <= req_wdata_in[win_idx];
          wstrb_q <= req_wstrb_in[win_idx];
        end
      end else if (complete) begin
        rr_q     <= owner_next;
        squash_q <= 1'b0;
      end else if (flush_in && !we_q) begin
        squash_q <= 1'b1;
      end
    end
  end

  assign dcache_req_out     = (state_q == BUSY);
  assign busy_out           = (state_q == BUSY);
  assign dcache_we_out      = we_q;
  assign dcache_addr_pa_out = addr_q;
  assign dcache_wdata_out   = wdata_q;
  assign dcache_wstrb_out   = wstrb_q;
  assign grant_idx_out      = owner_q;

  a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({req_ack_out, req_err_out}));
  a_rdata_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (req_ack_out == '0) |-> (req_rdata_out == '0));

endmodule

// File: doc/supernova_dcache_arbiter.md
SUPERNOVA_DCACHE_ARBITER -- requirements
Module: supernova_dcache_arbiter

Interface
REQ-001 Parameter N_REQ, default 3; number of D-Cache requesters (0 = page-table walker, 1 = LSQ, 2 = store drain).
REQ-002 Parameter TIMEOUT_CYCLES, default 255; ack-wait limit, used only with timeout compiled in.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush_in  input  1  pipeline redirect; squashes response of in-flight non-store access.
REQ-006 req_valid_in  input  N_REQ  per-requester request; held high until matching ack or err.
REQ-007 req_we_in  input  N_REQ  1 = store, 0 = load.
REQ-008 req_addr_in  input  N_REQ x stu_pkg::PHYS_ADDR_SIZE  physical address.
REQ-009 req_wdata_in  input  N_REQ x stu_pkg::XLEN  store data.
REQ-010 req_wstrb_in  input  N_REQ x 8  byte strobes.
REQ-011 req_ack_out  output  N_REQ  one-cycle completion pulse to owner.
REQ-012 req_err_out  output  N_REQ  one-cycle timeout pulse to owner.
REQ-013 req_rdata_out  output  stu_pkg::XLEN  load data, valid with req_ack_out.
REQ-014 dcache_req_out, dcache_we_out  output  1 each  D-Cache request and write-enable.
REQ-015 dcache_addr_pa_out  output  stu_pkg::PHYS_ADDR_SIZE; dcache_wdata_out  output  stu_pkg::XLEN; dcache_wstrb_out  output  8.
REQ-016 dcache_rdata_in  input  stu_pkg::XLEN; dcache_ack_in  input  1  D-Cache response.
REQ-017 busy_out  output  1  high while in BUSY; grant_idx_out  output  $clog2(N_REQ)  current owner.

Function
REQ-018 FSM states IDLE and BUSY; exactly one access outstanding at any time.
REQ-019 IDLE: if any req_valid_in set, select winner round-robin starting at rr_ptr, latch its index, addr, we, wdata, wstrb into registers, go BUSY next cycle.
REQ-020 All dcache_* outputs driven from latched registers; dcache_req_out high every cycle in BUSY, low in IDLE; request appears cycle after selection.
REQ-021 BUSY with dcache_ack_in: req_ack_out[owner] pulses same cycle, req_rdata_out = dcache_rdata_in combinationally, FSM to IDLE, rr_ptr <= owner+1 wrapping at N_REQ-1 -> 0.
REQ-022 Arbiter returns to IDLE for one cycle between accesses; back-to-back grant throughput one access per two cycles minimum.
REQ-023 req_rdata_out is 0 whenever no req_ack_out bit is set.
REQ-024 flush_in during BUSY with latched we=0: set squash flag; access still held until dcache_ack_in; on ack req_ack_out suppressed, FSM to IDLE.
REQ-025 flush_in during BUSY with we=1: no effect; store completes and acks normally.
REQ-026 flush_in in IDLE: no grant that cycle; squash flag cleared on every IDLE entry.
REQ-027 Requester dropping req_valid_in while BUSY does not abort the access.
REQ-028 At most one bit of req_ack_out and req_err_out set per cycle, never both.

Reset
REQ-029 rst_n low at clock edge: FSM IDLE, rr_ptr 0, squash 0, timeout counter 0, latched registers 0.
REQ-030 During and after reset: dcache_req_out, dcache_we_out, busy_out 0; dcache_addr_pa_out, dcache_wdata_out, dcache_wstrb_out, grant_idx_out 0; req_ack_out, req_err_out 0.
REQ-031 Reset mid-BUSY abandons access; late dcache_ack_in after reset is ignored in IDLE.

Configuration
REQ-032 Macro SUPERNOVA_DCACHE_ARB_TIMEOUT_EN defined: counter clears on BUSY entry, increments each BUSY cycle without ack; reaching TIMEOUT_CYCLES pulses req_err_out[owner] (suppressed if squashed), drops dcache_req_out, returns IDLE, advances rr_ptr.
REQ-033 Macro undefined: no counter, BUSY waits indefinitely, req_err_out tied 0.

Verification
REQ-034 Reset then req_valid_in=3'b111 held: grants in order 0,1,2,0; each dcache_req_out rises one cycle after selection.
REQ-035 Load req1 addr 0x8000_1000, ack after 3 cycles with rdata 0xDEAD_BEEF -> req_ack_out=3'b010 one cycle, req_rdata_out=0xDEAD_BEEF.
REQ-036 Load req1 in BUSY, flush_in pulsed, ack 2 cycles later -> req_ack_out stays 0, busy_out falls.
REQ-037 Store req2 wdata 0x1234, wstrb 0x0F, flush_in mid-access -> dcache_we_out=1, req_ack_out=3'b100 on ack.
REQ-038 With timeout macro and TIMEOUT_CYCLES=4, no ack -> req_err_out[owner] pulse at 4th BUSY cycle, next requester granted.
REQ-039 rst_n low for one cycle while BUSY, then ack asserted -> no req_ack_out, all outputs 0.
